// File: rtl/noc_link_bridge.sv
// Single-clock repeater between two NoC async-FIFO link ports: reads the remote
// FIFO on the ingress side and acts as the FIFO writer toward the peer on egress.
module noc_link_bridge #(
  parameter int unsigned PACKET_SIZE = 128,
  parameter int unsigned AWIDTH      = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   en_i,
  input  logic [PACKET_SIZE-1:0] in_data_i,
  input  logic [AWIDTH:0]        in_waddr_i,
  output logic [AWIDTH:0]        in_raddr_o,
  output logic [PACKET_SIZE-1:0] out_data_o,
  output logic [AWIDTH:0]        out_waddr_o,
  input  logic [AWIDTH:0]        out_raddr_i,
  output logic [AWIDTH:0]        fill_level_o,
  output logic [31:0]            pkt_cnt_o
);

  localparam int unsigned PW    = AWIDTH + 1;
  localparam int unsigned DEPTH = 1 << AWIDTH;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Low AWIDTH bits of gray2bin(g): the buffer index of a Gray pointer.
  function automatic logic [AWIDTH-1:0] gray2idx(input logic [PW-1:0] g);
    logic [AWIDTH-1:0] idx;
    logic              acc;
    acc = g[PW-1];
    for (int i = AWIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ g[i];
      idx[i] = acc;
    end
    return idx;
  endfunction

  logic [PW-1:0]          ws_sync_q [SYNC_STAGES];
  logic [PW-1:0]          rs_sync_q [SYNC_STAGES];
  logic [PW-1:0]          rbin_q, rbin_d;
  logic [PW-1:0]          wbin_q, wbin_d;
  logic [PW-1:0]          rgray_q, wgray_q;
  logic [PW-1:0]          fill_q, fill_d;
  logic [31:0]            pkt_cnt_q, pkt_cnt_d;
  logic [PACKET_SIZE-1:0] mem_q [DEPTH];

  logic [PW-1:0] ws_gray, rs_gray;
  logic          ingress_empty, egress_full, xfer;

  assign ws_gray = ws_sync_q[SYNC_STAGES-1];
  assign rs_gray = rs_sync_q[SYNC_STAGES-1];

  assign ingress_empty = (rgray_q == ws_gray);
  assign egress_full   = (wgray_q == {~rs_gray[AWIDTH:AWIDTH-1], rs_gray[AWIDTH-2:0]});
  assign xfer          = en_i & ~ingress_empty & ~egress_full;

  // Pointer, fill and counter next-state.
  always_comb begin
    rbin_d    = rbin_q;
    wbin_d    = wbin_q;
    pkt_cnt_d = pkt_cnt_q;
    fill_d    = wbin_q - gray2bin(rs_gray);
    if (xfer) begin
      rbin_d    = rbin_q + PW'(1);
      wbin_d    = wbin_q + PW'(1);
      pkt_cnt_d = pkt_cnt_q + 32'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        ws_sync_q[i] <= '0;
        rs_sync_q[i] <= '0;
      end
      rbin_q    <= '0;
      wbin_q    <= '0;
      rgray_q   <= '0;
      wgray_q   <= '0;
      fill_q    <= '0;
      pkt_cnt_q <= '0;
    end else begin
      ws_sync_q[0] <= in_waddr_i;
      rs_sync_q[0] <= out_raddr_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        ws_sync_q[i] <= ws_sync_q[i-1];
        rs_sync_q[i] <= rs_sync_q[i-1];
      end
      rbin_q    <= rbin_d;
      wbin_q    <= wbin_d;
      rgray_q   <= bin2gray(rbin_d);
      wgray_q   <= bin2gray(wbin_d);
      fill_q    <= fill_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Egress storage is not reset; entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (xfer) mem_q[wbin_q[AWIDTH-1:0]] <= in_data_i;
  end

  assign out_data_o   = mem_q[gray2idx(out_raddr_i)];
  assign in_raddr_o   = rgray_q;
  assign out_waddr_o  = wgray_q;
  assign fill_level_o = fill_q;
  assign pkt_cnt_o    = pkt_cnt_q;

endmodule
